// File: rtl/beep_sched_pkg.sv
// Shared definitions for the buzzer scheduler: FSM state encoding, idle owner code
// and the note divider periods used by the melody sequencer and the alarm source.
package beep_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [1:0] OWNER_NONE = 2'd3;

   localparam int unsigned CLK_PRE_HZ = 50_000_000;

   function automatic logic [16:0] note_period(input int unsigned clk_hz, input int unsigned tone_hz);
      return 17'(clk_hz / tone_hz);
   endfunction

   // Fifth octave: the fourth octave's periods overflow the 17-bit divider at 50 MHz.
   localparam logic [16:0] NOTE_DO  = note_period(CLK_PRE_HZ, 523);
   localparam logic [16:0] NOTE_RE  = note_period(CLK_PRE_HZ, 587);
   localparam logic [16:0] NOTE_MI  = note_period(CLK_PRE_HZ, 659);
   localparam logic [16:0] NOTE_FA  = note_period(CLK_PRE_HZ, 698);
   localparam logic [16:0] NOTE_SOL = note_period(CLK_PRE_HZ, 784);
   localparam logic [16:0] NOTE_LA  = note_period(CLK_PRE_HZ, 880);
   localparam logic [16:0] NOTE_SI  = note_period(CLK_PRE_HZ, 988);

endpackage

// File: rtl/beep_ms_timer.sv
// Millisecond timer: a TICK_MS-cycle prescaler feeding a 16-bit ms counter.
// Reports the final cycle of the target millisecond and the cycle before it.
module beep_ms_timer
   import beep_sched_pkg::*;
#(
   parameter int unsigned TICK_MS = 50_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        load,
   input  logic        run,
   input  logic [15:0] target,
   output logic        last,
   output logic        almost
);

   localparam int unsigned TW = (TICK_MS > 1) ? $clog2(TICK_MS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_MS - 1);

   logic [TW-1:0] tick_cnt;
   logic [TW-1:0] tick_nxt;
   logic [15:0]   ms_cnt;
   logic [15:0]   ms_nxt;
   logic [15:0]   target_q;
   logic          wrap;

   always_comb begin
      wrap     = (tick_cnt == TICK_LAST);
      tick_nxt = tick_cnt;
      ms_nxt   = ms_cnt;
      if (run) begin
         tick_nxt = wrap ? '0 : tick_cnt + 1'b1;
         if (wrap) begin
            ms_nxt = ms_cnt + 16'd1;
         end
      end
   end

   // almost looks one cycle ahead so the owner can register a pulse into the final cycle
   assign last   = run && wrap && (ms_cnt == target_q);
   assign almost = run && (tick_nxt == TICK_LAST) && (ms_nxt == target_q);

   always_ff @(posedge clk) begin
      if (rst_n) begin
         tick_cnt <= '0;
         ms_cnt   <= '0;
         target_q <= '0;
      end else begin
         if (clear) begin
            tick_cnt <= '0;
            ms_cnt   <= '0;
         end else begin
            tick_cnt <= tick_nxt;
            ms_cnt   <= ms_nxt;
         end
         if (load) begin
            target_q <= target;
         end
      end
   end

endmodule

// File: rtl/beep_sched.sv
// Shared-buzzer scheduler: fixed-priority arbitration of alarm, key click and melody
// onto one tone channel, with note timing, articulation gap and alarm preemption.
module beep_sched
   import beep_sched_pkg::*;
#(
   parameter int unsigned CLK_PRE = 50_000_000,
   parameter int unsigned TICK_MS = CLK_PRE / 1000,
   parameter int unsigned GAP_MS  = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  req,
   input  logic [16:0] period0,
   input  logic [16:0] period1,
   input  logic [16:0] period2,
   input  logic [15:0] dur0,
   input  logic [15:0] dur1,
   input  logic [15:0] dur2,
   output logic [2:0]  ack,
   output logic [2:0]  done,
   output logic [2:0]  preempt,
   output logic        tone_en,
   output logic [16:0] tone_period,
   output logic        busy,
   output logic [1:0]  owner
);

   localparam logic [15:0] GAP_TARGET = 16'(GAP_MS - 1);
   localparam bit          GAP_ONE    = (GAP_MS * TICK_MS == 1);

   state_t      state, state_n;
   logic [1:0]  owner_n;
   logic [2:0]  ack_n, done_n, preempt_n;
   logic        tone_en_n;
   logic [16:0] period_n;
   logic [15:0] dur_q, dur_n;
   logic [1:0]  win;
   logic [16:0] sel_period;
   logic [15:0] sel_dur;
   logic [2:0]  owner_oh;
   logic        alarm_hit;
   logic        tmr_clear, tmr_load, tmr_last, tmr_almost;
   logic [15:0] tmr_target;

   beep_ms_timer #(.TICK_MS(TICK_MS)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (tmr_clear),
      .load   (tmr_load),
      .run    ((state == ST_PLAY) || (state == ST_GAP)),
      .target (tmr_target),
      .last   (tmr_last),
      .almost (tmr_almost)
   );

   always_comb begin
      win        = 2'd2;
      sel_period = period2;
      sel_dur    = dur2;
      if (req[0]) begin
         win        = 2'd0;
         sel_period = period0;
         sel_dur    = dur0;
      end else if (req[1]) begin
         win        = 2'd1;
         sel_period = period1;
         sel_dur    = dur1;
      end
   end

   assign owner_oh  = 3'b001 << owner;
   assign alarm_hit = req[0] && (owner != 2'd0);

   always_comb begin
      state_n    = state;
      owner_n    = owner;
      tone_en_n  = tone_en;
      period_n   = tone_period;
      dur_n      = dur_q;
      ack_n      = '0;
      done_n     = '0;
      preempt_n  = '0;
      tmr_clear  = 1'b0;
      tmr_load   = 1'b0;
      tmr_target = '0;
      case (state)
         ST_IDLE: begin
            if (|req) begin
               state_n    = ST_PLAY;
               owner_n    = win;
               ack_n      = 3'b001 << win;
               period_n   = sel_period;
               dur_n      = sel_dur;
               tone_en_n  = (sel_dur != 16'd0) && (sel_period > 17'd1);
               tmr_clear  = 1'b1;
               tmr_load   = 1'b1;
               tmr_target = sel_dur - 16'd1;
            end
         end
         ST_PLAY: begin
            // A zero-length note completes immediately; completion outranks the alarm.
            if (dur_q == 16'd0) begin
               done_n    = owner_oh;
               state_n   = ST_IDLE;
               owner_n   = OWNER_NONE;
               tone_en_n = 1'b0;
            end else if (alarm_hit) begin
               preempt_n = owner_oh;
               state_n   = ST_IDLE;
               owner_n   = OWNER_NONE;
               tone_en_n = 1'b0;
            end else if (tmr_last) begin
               state_n    = ST_GAP;
               tone_en_n  = 1'b0;
               tmr_clear  = 1'b1;
               tmr_load   = 1'b1;
               tmr_target = GAP_TARGET;
               if (GAP_ONE) begin
                  done_n = owner_oh;
               end
            end
         end
         ST_GAP: begin
            // done is already showing in the final gap cycle, so it beats a late alarm.
            if (tmr_last) begin
               state_n = ST_IDLE;
               owner_n = OWNER_NONE;
            end else if (alarm_hit) begin
               preempt_n = owner_oh;
               state_n   = ST_IDLE;
               owner_n   = OWNER_NONE;
            end else if (tmr_almost) begin
               done_n = owner_oh;
            end
         end
         default: begin
            state_n   = ST_IDLE;
            owner_n   = OWNER_NONE;
            tone_en_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state       <= ST_IDLE;
         owner       <= OWNER_NONE;
         ack         <= '0;
         done        <= '0;
         preempt     <= '0;
         tone_en     <= 1'b0;
         tone_period <= '0;
         dur_q       <= '0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         owner       <= owner_n;
         ack         <= ack_n;
         done        <= done_n;
         preempt     <= preempt_n;
         tone_en     <= tone_en_n;
         tone_period <= period_n;
         dur_q       <= dur_n;
         busy        <= (state_n != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_beep_sched.sv
// Directed bench for beep_sched at CLK_PRE=10_000 (10 cycles per ms) and a 2 ms gap.
module tb_beep_sched;
   import beep_sched_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req;
   logic [16:0] period0, period1, period2;
   logic [15:0] dur0, dur1, dur2;
   logic [2:0]  ack, done, preempt;
   logic        tone_en;
   logic [16:0] tone_period;
   logic        busy;
   logic [1:0]  owner;

   int vecCount  = 0;
   int missCount = 0;
   int cyc       = 0;

   beep_sched #(.CLK_PRE(10_000), .GAP_MS(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .period0     (period0),
      .period1     (period1),
      .period2     (period2),
      .dur0        (dur0),
      .dur1        (dur1),
      .dur2        (dur2),
      .ack         (ack),
      .done        (done),
      .preempt     (preempt),
      .tone_en     (tone_en),
      .tone_period (tone_period),
      .busy        (busy),
      .owner       (owner)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500_000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish before 500us");
      $fatal(1, "[TB] timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] r, input int idx, input logic [16:0] p, input logic [15:0] d);
      req = r;
      case (idx)
         0: begin period0 = p; dur0 = d; end
         1: begin period1 = p; dur1 = d; end
         default: begin period2 = p; dur2 = d; end
      endcase
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      vecCount++;
      if (observed != expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Starting at the current cycle (index 0), steps until done or preempt shows up.
   task automatic watchNote(input int maxCyc, output int highCnt, output int doneAt,
                            output int doneVal, output int preemptAt);
      highCnt   = 0;
      doneAt    = -1;
      doneVal   = 0;
      preemptAt = -1;
      for (int i = 0; i < maxCyc; i++) begin
         if (tone_en) highCnt++;
         if (done != 3'b000) begin
            doneAt  = i;
            doneVal = int'(done);
            break;
         end
         if (preempt != 3'b000) begin
            preemptAt = i;
            break;
         end
         step();
      end
   endtask

   int hi, dAt, dVal, pAt;
   int seqDur [5];
   logic [16:0] seqPer [5];
   int ackCyc [5];

   initial begin
      rst_n = 1'b1;
      req = '0;
      period0 = '0; period1 = '0; period2 = '0;
      dur0 = '0; dur1 = '0; dur2 = '0;
      step();
      step();
      checkOutput("rst_tone_en", int'(tone_en), 0);
      checkOutput("rst_period", int'(tone_period), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_owner", int'(owner), 3);
      checkOutput("rst_pulses", int'({ack, done, preempt}), 0);
      rst_n = 1'b0;
      step();

      // single melody note
      applyStimulus(3'b100, 2, 17'd95, 16'd3);
      step();
      checkOutput("single_ack", int'(ack), 4);
      checkOutput("single_owner", int'(owner), 2);
      checkOutput("single_busy", int'(busy), 1);
      checkOutput("single_period", int'(tone_period), 95);
      req = 3'b000;
      watchNote(100, hi, dAt, dVal, pAt);
      checkOutput("single_high", hi, 30);
      checkOutput("single_done_at", dAt, 49);
      checkOutput("single_done_val", dVal, 4);
      checkOutput("single_busy_last", int'(busy), 1);
      step();
      checkOutput("single_owner_idle", int'(owner), 3);
      checkOutput("single_busy_idle", int'(busy), 0);

      // priority: key beats melody, melody served after one idle cycle
      applyStimulus(3'b110, 1, 17'd50, 16'd1);
      applyStimulus(3'b110, 2, 17'd60, 16'd1);
      step();
      checkOutput("prio_ack", int'(ack), 2);
      checkOutput("prio_owner", int'(owner), 1);
      req = 3'b100;
      watchNote(100, hi, dAt, dVal, pAt);
      checkOutput("prio_high", hi, 10);
      checkOutput("prio_done_at", dAt, 29);
      checkOutput("prio_done_val", dVal, 2);
      step();
      checkOutput("prio_idle_ack", int'(ack), 0);
      checkOutput("prio_idle_busy", int'(busy), 0);
      step();
      checkOutput("prio_ack2", int'(ack), 4);
      checkOutput("prio_period2", int'(tone_period), 60);
      req = 3'b000;
      watchNote(100, hi, dAt, dVal, pAt);
      checkOutput("prio_done2_at", dAt, 29);
      checkOutput("prio_done2_val", dVal, 4);
      step();

      // alarm preempts a melody note at ms 4
      applyStimulus(3'b100, 2, 17'd95, 16'd10);
      step();
      checkOutput("pre_ack_mel", int'(ack), 4);
      req = 3'b000;
      repeat (40) step();
      checkOutput("pre_tone_before", int'(tone_en), 1);
      applyStimulus(3'b001, 0, 17'd33, 16'd2);
      step();
      checkOutput("pre_pulse", int'(preempt), 4);
      checkOutput("pre_tone_off", int'(tone_en), 0);
      checkOutput("pre_no_done", int'(done), 0);
      checkOutput("pre_owner", int'(owner), 3);
      step();
      checkOutput("pre_ack_alarm", int'(ack), 1);
      checkOutput("pre_alarm_period", int'(tone_period), 33);
      req = 3'b000;
      watchNote(100, hi, dAt, dVal, pAt);
      checkOutput("pre_alarm_high", hi, 20);
      checkOutput("pre_alarm_done_at", dAt, 39);
      checkOutput("pre_alarm_done_val", dVal, 1);
      checkOutput("pre_alarm_no_preempt", pAt, -1);
      step();

      // rest note: period 1 keeps the tone off but timing is unchanged
      applyStimulus(3'b010, 1, 17'd1, 16'd2);
      step();
      checkOutput("rest_ack", int'(ack), 2);
      checkOutput("rest_tone", int'(tone_en), 0);
      req = 3'b000;
      watchNote(100, hi, dAt, dVal, pAt);
      checkOutput("rest_high", hi, 0);
      checkOutput("rest_done_at", dAt, 39);
      checkOutput("rest_done_val", dVal, 2);
      step();

      // zero duration: done right after ack, no tone
      applyStimulus(3'b010, 1, 17'd80, 16'd0);
      step();
      checkOutput("zero_ack", int'(ack), 2);
      checkOutput("zero_tone", int'(tone_en), 0);
      req = 3'b000;
      step();
      checkOutput("zero_done", int'(done), 2);
      checkOutput("zero_tone2", int'(tone_en), 0);
      step();
      checkOutput("zero_idle_busy", int'(busy), 0);
      checkOutput("zero_done_clear", int'(done), 0);

      // reset in the middle of a note
      applyStimulus(3'b100, 2, 17'd95, 16'd3);
      step();
      checkOutput("rstmid_ack", int'(ack), 4);
      req = 3'b000;
      repeat (5) step();
      rst_n = 1'b1;
      step();
      rst_n = 1'b0;
      checkOutput("rstmid_tone", int'(tone_en), 0);
      checkOutput("rstmid_busy", int'(busy), 0);
      checkOutput("rstmid_owner", int'(owner), 3);
      checkOutput("rstmid_period", int'(tone_period), 0);
      checkOutput("rstmid_pulses", int'({done, preempt}), 0);
      step();
      checkOutput("rstmid_quiet", int'({done, preempt, busy}), 0);
      applyStimulus(3'b010, 1, 17'd70, 16'd1);
      step();
      checkOutput("rstmid_fresh_ack", int'(ack), 2);
      checkOutput("rstmid_fresh_period", int'(tone_period), 70);
      req = 3'b000;
      watchNote(100, hi, dAt, dVal, pAt);
      checkOutput("rstmid_fresh_done_at", dAt, 29);
      step();

      // melody sequencer: one cycle to fetch the next note after done, then request
      seqDur = '{1, 2, 1, 3, 1};
      seqPer = '{NOTE_DO, NOTE_RE, NOTE_MI, NOTE_FA, NOTE_SOL};
      for (int k = 0; k < 5; k++) begin
         applyStimulus(3'b100, 2, seqPer[k], 16'(seqDur[k]));
         step();
         checkOutput("seq_ack", int'(ack), 4);
         checkOutput("seq_period", int'(tone_period), int'(seqPer[k]));
         ackCyc[k] = cyc;
         if (k > 0) checkOutput("seq_spacing", ackCyc[k] - ackCyc[k-1], (seqDur[k-1] + 2) * 10 + 2);
         req = 3'b000;
         watchNote(200, hi, dAt, dVal, pAt);
         checkOutput("seq_done_val", dVal, 4);
         step();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/beep_sched.md
# beep_sched

Shared-buzzer scheduler for the tone generator: arbitrates three note requesters (alarm, key click, melody sequencer) onto a single tone channel. It latches the winner's divider period and duration, times the note in millisecond ticks, and inserts a fixed silent gap between notes for articulation. It drives the period/enable inputs of the PWM tone generator and returns per-requester ack/done/preempt pulses.

## Interface
- CLK_PRE, 50_000_000, clock frequency in Hz
- TICK_MS, CLK_PRE/1000, clock cycles per 1 ms tick
- GAP_MS, 20, silent gap after each note, in ms (≥1)

Clock and reset: one clock; reset is synchronous and active-high.

- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-high (1 = reset)
- req  in  3  level requests; bit0 alarm, bit1 key click, bit2 melody
- period0/1/2  in  17 each  tone divider period (clocks per tone cycle) per requester
- dur0/1/2  in  16 each  note duration in ms per requester
- ack  out  3  one-cycle pulse: request accepted, inputs latched
- done  out  3  one-cycle pulse: note plus gap completed
- preempt  out  3  one-cycle pulse: note aborted by the alarm
- tone_en  out  1  1 = generator sounds latched period
- tone_period  out  17  latched divider period to the generator
- busy  out  1  1 in any state except IDLE
- owner  out  2  index of the current grant; 3 when idle

## Operation
- States: IDLE, PLAY, GAP.
- **IDLE:** if any req bit is set, grant the lowest set index (fixed priority alarm > key > melody).
  - Latch period/dur of the winner, set owner, pulse ack[winner].
  - Go to PLAY; the ms-tick counter and duration counter are cleared.
- **PLAY:**
  - tone_en = 1, except when the latched period ≤ 1, which is a rest: tone_en = 0, timing unchanged.
  - Tick counter wraps at TICK_MS−1. Each wrap increments the ms counter.
  - When the ms counter reaches dur−1 at a wrap, go to GAP.
- **GAP:**
  - tone_en = 0 for GAP_MS ms.
  - At the end, pulse done[owner] and go to IDLE (owner = 3).
- **dur = 0:** ack, then done on the following cycle. tone_en is never asserted and GAP is skipped.
- **Preemption:** in PLAY or GAP with owner ≠ 0 and req[0] = 1:
  - pulse preempt[owner], drop tone_en, go to IDLE the next cycle;
  - done is not issued for the aborted note.
  - The alarm itself is never preempted.
- **Requester handshake:** a requester must deassert req on the cycle after ack, or it is re-granted after done. period/dur inputs are sampled only on the grant cycle.
- **Simultaneous events:**
  - done completion and req[0] on the same cycle: done wins, and the alarm is granted from IDLE normally.
  - Several req bits in IDLE: only the highest-priority bit is acked.
- **Width rules:**
  - The tick counter is sized by $clog2(TICK_MS).
  - The ms counter is 16 bits and covers both dur and GAP_MS; GAP_MS must be < 65536.
- **Reset** (any state, including mid-note):
  - state IDLE; tone_en 0; tone_period 0; ack/done/preempt 0; busy 0; owner 3; counters 0.
  - Latched period/dur are cleared.

## Timing
- **Grant latency:** req seen high in IDLE at edge N → ack, busy, owner and tone_en valid after edge N+1.
- **Note length:** tone_en high for exactly dur×TICK_MS cycles. It is followed by exactly GAP_MS×TICK_MS cycles low, and done pulses in the last GAP cycle.
- **Back-to-back:** at least one IDLE cycle between done and the next ack. The melody sequencer therefore sees a period of (dur+GAP_MS)×TICK_MS+2 cycles per note.
- **Preemption:** preempt and tone_en=0 appear one cycle after req[0] is sampled. The alarm ack follows one cycle later.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- A shared package holds:
  - state encoding (IDLE/PLAY/GAP);
  - the OWNER_NONE = 3 constant;
  - note period constants (DO..SI as CLK_PRE/freq) used by the melody sequencer and the alarm source.
- One natural sub-module, beep_ms_timer: tick prescaler plus 16-bit ms counter, with clear, load-target and done outputs. It is instantiated once and reused for both PLAY and GAP.
- Arbiter and FSM stay in beep_sched.

## Test plan
All scenarios use CLK_PRE = 10_000 (TICK_MS = 10) and GAP_MS = 2.
- **Single note:** req[2] with period2 = 95, dur2 = 3.
  - ack[2] one cycle later; tone_period = 95; tone_en high 30 cycles, then low 20.
  - done[2] at the last low cycle; owner returns to 3.
- **Priority:** req = 3'b110 in IDLE → only ack[1]. After done[1] with req[2] still high → ack[2] after one IDLE cycle.
- **Preemption:** melody playing dur = 10; req[0] at ms 4.
  - preempt[2] next cycle and tone_en = 0; no done[2].
  - ack[0] the following cycle; alarm plays its full duration.
- **Rest and zero duration:**
  - period1 = 1, dur1 = 2 → tone_en stays 0, done[1] after 40 cycles.
  - dur1 = 0 → done[1] the cycle after ack[1].
- **Reset mid-note:** assert rst_n = 1 for one cycle during PLAY.
  - Next cycle: tone_en 0, busy 0, owner 3, no done or preempt pulse.
  - A fresh request is acked normally afterwards.
- **Sequencer loop:** melody re-requests on every done for 5 notes. Each ack is spaced exactly (dur+2)×10+2 cycles apart.
